div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter.sv | 152 +++++++++++++++
 tb/tb_div_iter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider (signed/unsigned), one quotient
// bit per cycle, IDLE/BUSY/DONE control with cancel and hazard-unit stall.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and
// completes one cycle after start (quotient=0, remainder=dividend).
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             stall,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;     // partial remainder magnitude
  logic [WIDTH-1:0] dq_q, dq_d;         // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;     // divisor magnitude
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH:0]   shl;
  logic             borrow;
  logic [WIDTH-1:0] prem_step, dq_step;
  logic [WIDTH-1:0] mag_a, mag_b;

  // One restoring step plus operand magnitudes for capture.
  always_comb begin
    shl       = {prem_q, dq_q[WIDTH-1]};
    borrow    = shl < {1'b0, dvsr_q};
    prem_step = borrow ? shl[WIDTH-1:0] : WIDTH'(shl - {1'b0, dvsr_q});
    dq_step   = {dq_q[WIDTH-2:0], ~borrow};
    mag_a     = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    mag_b     = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  // Next-state, datapath loads and stall request.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prem_d      = prem_q;
    dq_d        = dq_q;
    dvsr_d      = dvsr_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    stall       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          stall   = 1'b1;
          dq_d    = mag_a;
          dvsr_d  = mag_b;
          prem_d  = '0;
          qneg_d  = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg_d  = signed_op & dividend[WIDTH-1];
          dz_d    = (divisor == '0);
          cnt_d   = CW'(WIDTH);
          state_d = BUSY;
`ifdef DIV_ZERO_FAST_EN
          if (divisor == '0) begin
            cnt_d       = '0;
            state_d     = DONE;
            quotient_d  = '0;
            remainder_d = dividend;
            div_zero_d  = 1'b1;
          end
`else
`endif
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          prem_d = prem_step;
          dq_d   = dq_step;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            // final step's results are committed directly on entry to DONE
            state_d     = DONE;
            quotient_d  = qneg_q ? -dq_step : dq_step;
            remainder_d = rneg_q ? -prem_step : prem_step;
            div_zero_d  = dz_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prem_q      <= '0;
      dq_q        <= '0;
      dvsr_q      <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prem_q      <= prem_d;
      dq_q        <= dq_d;
      dvsr_q      <= dvsr_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign ready     = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and randomized checks of div_iter (WIDTH=32) against
// a plain-arithmetic reference model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] quotient, remainder;
  logic        ready, stall, div_zero;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q = '0;
  logic [31:0] exp_r = '0;
  logic        exp_dz = 1'b0;

  div_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op), .cancel(cancel),
    .dividend(dividend), .divisor(divisor), .quotient(quotient),
    .remainder(remainder), .ready(ready), .stall(stall), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Division from the arithmetic rules: magnitudes, truncating divide, sign fix.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output int lat);
    logic [31:0] ma, mb, qm, rm;
    ma  = (s && a[31]) ? 32'd0 - a : a;
    mb  = (s && b[31]) ? 32'd0 - b : b;
    dz  = (b == 32'd0);
    lat = 33;
    if (b == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
      q   = 32'd0;
      r   = a;
      lat = 1;
      return;
`else
      qm = 32'hFFFF_FFFF;
      rm = ma;
`endif
    end else begin
      qm = ma / mb;
      rm = ma % mb;
    end
    q = (s && (a[31] ^ b[31])) ? 32'd0 - qm : qm;
    r = (s && a[31]) ? 32'd0 - rm : rm;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit cancel_in_done);
    logic [31:0] mq, mr;
    logic        mdz;
    int          lat;
    model(a, b, s, mq, mr, mdz, lat);
    @(negedge clk);
    start = 1'b1; cancel = 1'b0; signed_op = s; dividend = a; divisor = b;
    #1;
    chk("stall_accept", stall, 1);
    chk("hold_q", quotient, exp_q);
    chk("hold_r", remainder, exp_r);
    chk("hold_dz", div_zero, exp_dz);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      start = 1'b0;
      signed_op = ~s; dividend = $urandom; divisor = $urandom;
      cancel = cancel_in_done && (k == lat);
      #1;
      chk("ready", ready, (k == lat) ? 32'd1 : 32'd0);
      chk("stall", stall, (k == lat) ? 32'd0 : 32'd1);
    end
    chk("quotient", quotient, mq);
    chk("remainder", remainder, mr);
    chk("div_zero", div_zero, mdz);
    exp_q = mq; exp_r = mr; exp_dz = mdz;
    @(negedge clk);
    cancel = 1'b0;
    #1;
    chk("ready_drop", ready, 0);
    chk("stall_idle", stall, 0);
    chk("q_held", quotient, exp_q);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    bit          cd;

    // reset state; stall still follows the IDLE rule during reset
    #1;
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_ready", ready, 0);
    chk("rst_stall", stall, 0);
    start = 1'b1;
    #1;
    chk("rst_stall_start", stall, 1);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // directed values
    run_op(32'd100, 32'd7, 1'b0, 1'b0);
    chk("u100_7_q", quotient, 32'd14);
    chk("u100_7_r", remainder, 32'd2);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    chk("sm7_2_q", quotient, 32'hFFFF_FFFD);
    chk("sm7_2_r", remainder, 32'hFFFF_FFFF);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("mneg_q", quotient, 32'h8000_0000);
    chk("mneg_r", remainder, 32'd0);
    chk("mneg_dz", div_zero, 0);
    run_op(32'd5, 32'd0, 1'b0, 1'b0);
`ifdef DIV_ZERO_FAST_EN
    chk("u5_0_q", quotient, 32'd0);
`else
    chk("u5_0_q", quotient, 32'hFFFF_FFFF);
`endif
    chk("u5_0_r", remainder, 32'd5);
    chk("u5_0_dz", div_zero, 1);

    // randomized operations
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'd0 - $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      s  = $urandom_range(0, 1);
      cd = ($urandom_range(0, 3) == 0);
      run_op(a, b, s, cd);
    end

    // cancel mid-operation, then a fresh start right after
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
    #1;
    chk("cx_stall0", stall, 1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      cancel = (k == 10);
      #1;
      chk("cx_ready", ready, 0);
      chk("cx_stall", stall, 1);
    end
    run_op(32'd200, 32'd9, 1'b0, 1'b0);

    // cancel beats a simultaneous start
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; dividend = 32'd50; divisor = 32'd3;
    #1;
    chk("cs_stall", stall, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      #1;
      chk("cs_ready", ready, 0);
      chk("cs_stall_idle", stall, 0);
      chk("cs_q_held", quotient, exp_q);
    end

    // asynchronous reset in cycle 15 of an operation
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 15) rst = 1'b0;
      #1;
      chk("mr_ready", ready, 0);
    end
    chk("mr_q", quotient, 0);
    chk("mr_r", remainder, 0);
    chk("mr_dz", div_zero, 0);
    chk("mr_stall", stall, 0);
    exp_q = '0; exp_r = '0; exp_dz = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      chk("mr_no_ready", ready, 0);
    end

    // start held high: one accepted operation every 34 cycles
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd7;
    for (int k = 1; k <= 3 * 34; k++) begin
      @(negedge clk);
      #1;
      chk("b2b_ready", ready, (k % 34 == 33) ? 32'd1 : 32'd0);
      chk("b2b_stall", stall, (k % 34 == 33) ? 32'd0 : 32'd1);
    end
    start = 1'b0;
    chk("b2b_q", quotient, 32'd142);
    chk("b2b_r", remainder, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
